// File: rtl/gpio_serial_cfg_loader.sv
// gpio_serial_cfg_loader: holds one mode word per mprj_io pad and shifts the
// whole set into the two GPIO configuration chains, then strobes serial_load.
// Optional feature macro: GPIO_CFG_READBACK_EN adds the registered cfg_rdata port.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; store writable
// S_SHIFT_LO | serial_clock low; new bit presented on both data lines
// S_SHIFT_HI | serial_clock high; chains sample on the rising edge
// S_LOAD     | serial_load high for CLK_DIV cycles
// S_DONE     | one-cycle completion pulse; a new start is accepted here

module gpio_serial_cfg_loader #(
    parameter int                  NUM_IO   = 38,
    parameter int                  CFG_BITS = 13,
    parameter int                  CLK_DIV  = 4,
    parameter logic [CFG_BITS-1:0] CFG_INIT = 13'h0403
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_1,
    output logic                serial_data_2
`ifdef GPIO_CFG_READBACK_EN
    ,
    output logic [CFG_BITS-1:0] cfg_rdata
`endif
);

    localparam int HALF  = NUM_IO / 2;
    localparam int B     = CFG_BITS * HALF;
    localparam int BW    = $clog2(B);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q;
    logic [BW-1:0]       bit_q;
    logic [B-1:0]        sr1_q, sr2_q;
    logic [B-1:0]        pack1, pack2;
    logic [CFG_BITS-1:0] store [NUM_IO];
    logic                div_tc, last_bit, addr_ok, wr_en, accept, advance;

    assign div_tc   = (div_q == '0);
    assign last_bit = (bit_q == '0);
    assign addr_ok  = (int'(cfg_addr) < NUM_IO);
    assign wr_en    = cfg_we && addr_ok && !busy;
    assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign advance  = (state_q == S_SHIFT_HI) && div_tc && !last_bit;

    // Config store; frozen whenever a load is in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IO; i++) store[i] <= CFG_INIT;
        end else if (wr_en) begin
            store[cfg_addr] <= cfg_data;
        end
    end

    // Build both chain images with a same-cycle write folded in, so a start
    // coinciding with a write snapshots the new word.
    always_comb begin
        logic [CFG_BITS-1:0] w1, w2;
        pack1 = '0;
        pack2 = '0;
        w1    = '0;
        w2    = '0;
        for (int i = 0; i < HALF; i++) begin
            w1 = store[HALF-1-i];
            if (wr_en && int'(cfg_addr) == HALF - 1 - i) w1 = cfg_data;
            w2 = store[HALF+i];
            if (wr_en && int'(cfg_addr) == HALF + i) w2 = cfg_data;
            pack1[B-1-i*CFG_BITS -: CFG_BITS] = w1;
            pack2[B-1-i*CFG_BITS -: CFG_BITS] = w2;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_SHIFT_LO;
            S_SHIFT_LO: if (div_tc) state_d = S_SHIFT_HI;
            S_SHIFT_HI: if (div_tc) state_d = last_bit ? S_LOAD : S_SHIFT_LO;
            S_LOAD:     if (div_tc) state_d = S_DONE;
            S_DONE:     state_d = start ? S_SHIFT_LO : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State, phase timer, bit counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            sr1_q         <= '0;
            sr2_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
            serial_resetn <= 1'b0;
        end else begin
            state_q       <= state_d;
            serial_resetn <= 1'b1;
            busy          <= (state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI) ||
                             (state_d == S_LOAD);
            done          <= (state_d == S_DONE);
            serial_clock  <= (state_d == S_SHIFT_HI);
            serial_load   <= (state_d == S_LOAD);

            if (state_d != state_q)
                div_q <= DIV_W'(CLK_DIV - 1);
            else if (!div_tc)
                div_q <= div_q - DIV_W'(1);

            if (accept) begin
                bit_q         <= BW'(B - 1);
                serial_data_1 <= pack1[B-1];
                serial_data_2 <= pack2[B-1];
                sr1_q         <= pack1 << 1;
                sr2_q         <= pack2 << 1;
            end else if (advance) begin
                bit_q         <= bit_q - BW'(1);
                serial_data_1 <= sr1_q[B-1];
                serial_data_2 <= sr2_q[B-1];
                sr1_q         <= sr1_q << 1;
                sr2_q         <= sr2_q << 1;
            end
        end
    end

`ifdef GPIO_CFG_READBACK_EN
    // Registered readback, valid regardless of busy.
    always_ff @(posedge clock) begin
        if (reset)        cfg_rdata <= '0;
        else if (addr_ok) cfg_rdata <= store[cfg_addr];
        else              cfg_rdata <= '0;
    end
`endif

endmodule
